param_ram: RTL and testbench

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram.sv | 138 +++++++++++++
 tb/tb_param_ram.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_ram.sv
// Single-port word RAM with byte enables behind a valid/ready request/response pair.
// Responses appear RD_LAT edges after acceptance; one request is in flight at a time.
module param_ram #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_MODE == 1) ? DATA_W'(DEPTH - 1 - i) : '0;
    end
    return m;
  endfunction

  // Contents come from the declaration initialiser only; rst_n never touches them.
  mem_t mem_q = init_mem();

  state_t            state_q;
  logic [1:0]        cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              pend_err_q;

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] acc_data_d;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready.
  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign in_range  = 64'(req_addr) < 64'(DEPTH);
  assign idx       = IDX_W'(req_addr);

  always_comb begin
    acc_data_d = '0;
    if (!req_we && in_range) begin
      acc_data_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          mem_q[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Outputs are registered off the state: RESP spends its first cycle raising rsp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pend_data_q <= acc_data_d;
            pend_err_q  <= !in_range;
            if (RD_LAT == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= BUSY;
              cnt_q   <= 2'(RD_LAT - 1);
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pend_data_q;
            rsp_err_q   <= pend_err_q;
          end else if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_ram.sv
// Bench for param_ram: a RD_LAT=1 and a RD_LAT=3 instance share request inputs,
// each with its own expected-response queue and monitor.
module tb_param_ram;

  logic        clk;
  logic        rst_n;
  logic        req_valid1, req_valid3;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic [1:0]  dbg_state1;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;
  logic [1:0]  dbg_state3;

  logic [32:0] exp_q1[$];
  logic [32:0] exp_q3[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc1    = 0;
  int acc3    = 0;
  logic pv1   = 1'b0;
  logic pv3   = 1'b0;

  param_ram #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .RD_LAT(1), .INIT_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .dbg_state(dbg_state1)
  );

  param_ram #(.DATA_W(32), .DEPTH(512), .ADDR_W(32), .RD_LAT(3), .INIT_MODE(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .dbg_state(dbg_state3)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: present a request to instance sel (1 or 3), queue its expected response
  task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_d, input logic exp_e);
    int t;
    t = 0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!((sel == 1) ? req_ready1 : req_ready3) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready stuck low on instance %0d, got 0 expected 1", sel);
      return;
    end
    if (sel == 1) begin
      req_valid1 = 1'b1;
      exp_q1.push_back({exp_e, exp_d});
    end else begin
      req_valid3 = 1'b1;
      exp_q3.push_back({exp_e, exp_d});
    end
    @(posedge clk);
    #1;
    if (sel == 1) acc1 = cyc;
    else acc3 = cyc;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
  endtask

  task automatic drain(input int sel);
    int t;
    t = 0;
    while (((sel == 1) ? exp_q1.size() : exp_q3.size()) != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: instance %0d still waits for %0d responses, expected 0", sel,
               (sel == 1) ? exp_q1.size() : exp_q3.size());
      if (sel == 1) exp_q1.delete();
      else exp_q3.delete();
    end
  endtask

  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_d, input logic exp_e);
    issue(sel, we, addr, wdata, be, exp_d, exp_e);
    drain(sel);
  endtask

  // Scoreboard monitors: check latency on each rising rsp_valid, pop on each response transfer
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      pv1 = 1'b0;
    end else begin
      if (rsp_valid1 && !pv1) begin
        n_tests++;
        if (cyc - acc1 != 1) begin
          n_fail++;
          $display("FAIL latency1: got %0d expected 1", cyc - acc1);
        end
      end
      pv1 = rsp_valid1;
      if (rsp_valid1 && rsp_ready) begin
        n_tests++;
        if (exp_q1.size() == 0) begin
          n_fail++;
          $display("FAIL rsp1_unexpected: got err=%b data=%h expected no response", rsp_err1, rsp_rdata1);
        end else begin
          e = exp_q1.pop_front();
          if ({rsp_err1, rsp_rdata1} !== e) begin
            n_fail++;
            $display("FAIL rsp1: got err=%b data=%h expected err=%b data=%h",
                     rsp_err1, rsp_rdata1, e[32], e[31:0]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      pv3 = 1'b0;
    end else begin
      if (rsp_valid3 && !pv3) begin
        n_tests++;
        if (cyc - acc3 != 3) begin
          n_fail++;
          $display("FAIL latency3: got %0d expected 3", cyc - acc3);
        end
      end
      pv3 = rsp_valid3;
      if (rsp_valid3 && rsp_ready) begin
        n_tests++;
        if (exp_q3.size() == 0) begin
          n_fail++;
          $display("FAIL rsp3_unexpected: got err=%b data=%h expected no response", rsp_err3, rsp_rdata3);
        end else begin
          e = exp_q3.pop_front();
          if ({rsp_err3, rsp_rdata3} !== e) begin
            n_fail++;
            $display("FAIL rsp3: got err=%b data=%h expected err=%b data=%h",
                     rsp_err3, rsp_rdata3, e[32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    int rel;
    int t;
    rst_n      = 1'b0;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset_rsp_valid1", 64'(rsp_valid1), 64'd0);
    chk("reset_rsp_rdata1", 64'(rsp_rdata1), 64'd0);
    chk("reset_rsp_err1",   64'(rsp_err1),   64'd0);
    chk("reset_req_ready1", 64'(req_ready1), 64'd1);
    chk("reset_rsp_valid3", 64'(rsp_valid3), 64'd0);
    chk("reset_req_ready3", 64'(req_ready3), 64'd1);

    // First request is taken on the first edge after reset release
    rst_n = 1'b1;
    rel = cyc;
    issue(1, 1'b0, 32'd0, 32'h0, 4'h0, 32'd511, 1'b0);
    chk("first_accept_edge", 64'(acc1), 64'(rel + 1));
    drain(1);

    // RD_LAT=1 directed vectors
    txn(1, 1'b0, 32'd511, 32'h0, 4'h0, 32'd0, 1'b0);
    txn(1, 1'b1, 32'd5, 32'hAABBCCDD, 4'b0011, 32'd0, 1'b0);
    txn(1, 1'b0, 32'd5, 32'h0, 4'h0, 32'h0000CCDD, 1'b0);
    txn(1, 1'b1, 32'd512, 32'hDEADBEEF, 4'hF, 32'd0, 1'b1);
    txn(1, 1'b0, 32'd512, 32'h0, 4'h0, 32'd0, 1'b1);
    txn(1, 1'b0, 32'd0, 32'h0, 4'h0, 32'd511, 1'b0);
    txn(1, 1'b0, 32'd511, 32'h0, 4'h0, 32'd0, 1'b0);
    txn(1, 1'b0, 32'd6, 32'h0, 4'h0, 32'd505, 1'b0);
    txn(1, 1'b1, 32'd9, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
    txn(1, 1'b0, 32'd9, 32'h0, 4'h0, 32'd502, 1'b0);
    txn(1, 1'b1, 32'd10, 32'h11223344, 4'b1100, 32'd0, 1'b0);
    txn(1, 1'b0, 32'd10, 32'h0, 4'h0, 32'h112201F5, 1'b0);
    txn(1, 1'b0, 32'h8000_0005, 32'h0, 4'h0, 32'd0, 1'b1);
    txn(1, 1'b1, 32'h8000_0005, 32'h0BADF00D, 4'hF, 32'd0, 1'b1);
    txn(1, 1'b0, 32'd5, 32'h0, 4'h0, 32'h0000CCDD, 1'b0);

    // RD_LAT=3: response held while the consumer stalls
    rsp_ready = 1'b0;
    issue(3, 1'b0, 32'd3, 32'h0, 4'h0, 32'd508, 1'b0);
    t = 0;
    while (!rsp_valid3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hold_valid_seen", 64'(rsp_valid3), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid3), 64'd1);
      chk("hold_rsp_rdata", 64'(rsp_rdata3), 64'd508);
      chk("hold_rsp_err",   64'(rsp_err3),   64'd0);
      chk("hold_req_ready", 64'(req_ready3), 64'd0);
    end
    rsp_ready = 1'b1;
    drain(3);
    txn(3, 1'b1, 32'd600, 32'h0, 4'hF, 32'd0, 1'b1);

    // Reset while BUSY after a write: response dropped, memory keeps the write
    issue(3, 1'b1, 32'd7, 32'h12345678, 4'hF, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_rsp_valid", 64'(rsp_valid3), 64'd0);
    chk("rst_busy_state",     64'(dbg_state3), 64'd0);
    exp_q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
    txn(3, 1'b0, 32'd7, 32'h0, 4'h0, 32'h12345678, 1'b0);

    // Reset while RESP holds a response
    rsp_ready = 1'b0;
    issue(3, 1'b0, 32'd20, 32'h0, 4'h0, 32'd491, 1'b0);
    t = 0;
    while (!rsp_valid3 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("resp_valid_before_rst", 64'(rsp_valid3), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", 64'(rsp_valid3), 64'd0);
    chk("rst_resp_rsp_rdata", 64'(rsp_rdata3), 64'd0);
    exp_q3.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    txn(3, 1'b0, 32'd20, 32'h0, 4'h0, 32'd491, 1'b0);
    txn(1, 1'b0, 32'd7, 32'h0, 4'h0, 32'd504, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
